// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues one outstanding word read at a time, buffers returns for Decode.
// Latency: imemAck in cycle N presents that instruction (instructionValid=1) in cycle N+1.
// Backpressure: stall only blocks the pop; new requests stop once the buffer would be full.
module fetch_unit #(
    parameter int                      INSTRUCTION_WIDTH = 32,
    parameter int                      PC_WIDTH          = 16,
    parameter int                      OPCODE_WIDTH      = 5,
    parameter int                      FIFO_DEPTH        = 2,
    parameter logic [PC_WIDTH-1:0]     RESET_PC          = '0,
    parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE       = 5'b11111
) (
    input  logic                         clock,
    input  logic                         reset,
    output logic                         imemReq,
    output logic [PC_WIDTH-1:0]          imemAddr,
    input  logic                         imemAck,
    input  logic [INSTRUCTION_WIDTH-1:0] imemData,
    input  logic                         stall,
    input  logic                         branchTaken,
    input  logic [PC_WIDTH-1:0]          branchTarget,
    output logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic [PC_WIDTH-1:0]          instructionPc,
    output logic                         instructionValid,
    output logic                         halted
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] ST_ISSUE  = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    typedef struct packed {
        logic [INSTRUCTION_WIDTH-1:0] dat;
        logic [PC_WIDTH-1:0]          pc;
    } entry_t;

    logic [1:0]          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d, pc_inc;
    logic [PC_WIDTH-1:0] req_addr_q, req_addr_d;
    logic                squash_q, squash_d;

    entry_t              fifo_mem [FIFO_DEPTH];
    entry_t              head_q, head_d, push_entry;
    logic [PTR_W-1:0]    rd_ptr_q, wr_ptr_q, rd_ptr_pop;
    logic [CNT_W-1:0]    count_q, count_pop, count_d;
    logic                pop, push, is_halt;

    // Buffer bookkeeping: pop when Decode takes the head, push on a live ack, flush on redirect.
    always_comb begin
        pop            = (count_q != '0) && !stall;
        push           = (state_q == ST_WAIT) && imemAck && !squash_q && !branchTaken;
        is_halt        = (imemData[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH] == HALT_OPCODE);
        pc_inc         = pc_q + PC_WIDTH'(1);
        push_entry.dat = imemData;
        push_entry.pc  = req_addr_q;
        count_pop      = count_q - CNT_W'(pop);
        count_d        = branchTaken ? '0 : (count_pop + CNT_W'(push));
        rd_ptr_pop     = rd_ptr_q + PTR_W'(pop);
        head_d         = head_q;
        // The head register holds its last value when the buffer drains or is flushed.
        if (!branchTaken && (count_d != '0)) begin
            head_d = (count_pop == '0) ? push_entry : fifo_mem[rd_ptr_pop];
        end
    end

    // Fetch sequencing: request issue, ack handling, redirect squash and halt.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        squash_d   = squash_q;
        case (state_q)
            ST_ISSUE: begin
                if (branchTaken) begin
                    pc_d = branchTarget;
                end else if (count_pop < DEPTH_CNT) begin
                    state_d    = ST_WAIT;
                    req_addr_d = pc_q;
                end
            end
            ST_WAIT: begin
                if (squash_q) begin
                    // The in-flight read belongs to the old path; only the PC follows redirects.
                    if (branchTaken) pc_d = branchTarget;
                    if (imemAck) begin
                        state_d  = ST_ISSUE;
                        squash_d = 1'b0;
                    end
                end else if (branchTaken) begin
                    pc_d = branchTarget;
                    if (imemAck) state_d = ST_ISSUE;
                    else         squash_d = 1'b1;
                end else if (imemAck) begin
                    pc_d = pc_inc;
                    if (is_halt) begin
                        state_d = ST_HALTED;
                    end else if (count_d < DEPTH_CNT) begin
                        req_addr_d = pc_inc;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_HALTED: begin
                if (branchTaken) begin
                    pc_d    = branchTarget;
                    state_d = ST_ISSUE;
                end
            end
            default: state_d = ST_ISSUE;
        endcase
    end

    // Control state, PC and buffer pointers; reset returns to an empty buffer in ISSUE.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_ISSUE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            squash_q   <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            head_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            squash_q   <= squash_d;
            count_q    <= count_d;
            head_q     <= head_d;
            if (branchTaken) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                rd_ptr_q <= rd_ptr_pop;
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
        end
    end

    // Buffer storage is only ever read behind the count, so it carries no reset.
    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr_q] <= push_entry;
    end

    assign imemReq          = (state_q == ST_WAIT);
    assign imemAddr         = req_addr_q;
    assign instruction      = head_q.dat;
    assign instructionPc    = head_q.pc;
    assign instructionValid = (count_q != '0);
    assign halted           = (state_q == ST_HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios, then a randomized run against a transaction-level model.
// Outputs are sampled 1 time unit after each rising edge; inputs are driven at the same point.
// Memory responds from the bench with a configurable ack delay.
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        imemReq;
    logic [15:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemData;
    logic        stall;
    logic        branchTaken;
    logic [15:0] branchTarget;
    logic [31:0] instruction;
    logic [15:0] instructionPc;
    logic        instructionValid;
    logic        halted;

    always #5 clock = ~clock;

    fetch_unit dut (
        .clock           (clock),
        .reset           (reset),
        .imemReq         (imemReq),
        .imemAddr        (imemAddr),
        .imemAck         (imemAck),
        .imemData        (imemData),
        .stall           (stall),
        .branchTaken     (branchTaken),
        .branchTarget    (branchTarget),
        .instruction     (instruction),
        .instructionPc   (instructionPc),
        .instructionValid(instructionValid),
        .halted          (halted)
    );

    typedef struct packed {
        logic [31:0] dat;
        logic [15:0] pc;
    } exp_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          mem_delay = 0;
    int          wait_cnt  = 0;
    bit          halt_en   = 1'b0;
    logic [15:0] halt_addr = 16'h0;

    // Reference model state for the randomized phase.
    exp_t        q[$];
    exp_t        p_entry;
    logic [15:0] m_pc;
    logic [15:0] doomed_addr;
    bit          m_halted, doomed, p_flush, p_pop, p_push;
    bit          br, st, ak;
    logic [4:0]  opc;
    logic [31:0] rdat;
    logic [15:0] tgt;
    int          n_push;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic mem_respond();
        if (imemReq && (wait_cnt >= mem_delay)) begin
            imemAck  = 1'b1;
            imemData = (halt_en && imemAddr == halt_addr) ? 32'hF800_0000
                                                          : 32'h0800_0000 + {16'h0, imemAddr};
            wait_cnt = 0;
        end else begin
            imemAck  = 1'b0;
            wait_cnt = imemReq ? wait_cnt + 1 : 0;
        end
    endtask

    task automatic cyc();
        tick();
        mem_respond();
    endtask

    task automatic do_reset(input bit check);
        reset        = 1'b1;
        imemAck      = 1'b0;
        imemData     = 32'h0;
        stall        = 1'b0;
        branchTaken  = 1'b0;
        branchTarget = 16'h0;
        tick();
        tick();
        if (check) begin
            chk("rst_req",   imemReq, 0);
            chk("rst_addr",  imemAddr, 0);
            chk("rst_valid", instructionValid, 0);
            chk("rst_instr", instruction, 0);
            chk("rst_pc",    instructionPc, 0);
            chk("rst_halt",  halted, 0);
        end
        reset    = 1'b0;
        wait_cnt = 0;
    endtask

    initial begin
        // ---- Back-to-back fetch with an always-ready memory ----
        mem_delay = 0;
        do_reset(1'b1);
        cyc();
        chk("t1_req0",   imemReq, 1);
        chk("t1_addr0",  imemAddr, 0);
        chk("t1_valid0", instructionValid, 0);
        for (int i = 1; i <= 3; i++) begin
            cyc();
            chk("t1_addr",  imemAddr, i);
            chk("t1_valid", instructionValid, 1);
            chk("t1_pc",    instructionPc, i - 1);
            chk("t1_instr", instruction, 32'h0800_0000 + i - 1);
        end

        // ---- Decode stall fills the buffer, then release ----
        do_reset(1'b0);
        stall = 1'b1;
        for (int i = 0; i < 6; i++) cyc();
        chk("t2_req_off", imemReq, 0);
        chk("t2_valid",   instructionValid, 1);
        chk("t2_pc0",     instructionPc, 0);
        chk("t2_instr0",  instruction, 32'h0800_0000);
        stall = 1'b0;
        cyc();
        chk("t2_pc1",     instructionPc, 1);
        chk("t2_resume",  imemReq, 1);
        chk("t2_addr2",   imemAddr, 2);
        cyc();
        chk("t2_pc2",     instructionPc, 2);
        cyc();
        chk("t2_addr4",   imemAddr, 4);

        // ---- Slow memory: request held stable, single push ----
        mem_delay = 3;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t3_req_hold",  imemReq, 1);
            chk("t3_addr_hold", imemAddr, 5);
            if (i > 0) chk("t3_empty", instructionValid, 0);
        end
        cyc();
        chk("t3_valid", instructionValid, 1);
        chk("t3_pc5",   instructionPc, 5);
        chk("t3_instr", instruction, 32'h0800_0005);
        chk("t3_addr6", imemAddr, 6);
        cyc();
        chk("t3_nodup", instructionValid, 0);

        // ---- Redirect while a request is outstanding ----
        mem_delay = 0;
        do_reset(1'b0);
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (imemReq && imemAddr == 16'd6) break;
        end
        chk("t4_reach6", imemAddr, 6);
        mem_delay = 2;
        cyc();
        chk("t4_req7",  imemReq, 1);
        chk("t4_addr7", imemAddr, 7);
        branchTaken  = 1'b1;
        branchTarget = 16'h0040;
        cyc();
        branchTaken = 1'b0;
        chk("t4_flush",    instructionValid, 0);
        chk("t4_hold_req", imemReq, 1);
        chk("t4_hold7",    imemAddr, 7);
        cyc();
        chk("t4_ackcycle", imemAck, 1);
        cyc();
        chk("t4_dropped",  instructionValid, 0);
        chk("t4_reissue",  imemReq, 0);
        cyc();
        chk("t4_req40",    imemReq, 1);
        chk("t4_addr40",   imemAddr, 16'h0040);
        for (int i = 0; i < 10 && !instructionValid; i++) cyc();
        chk("t4_valid",    instructionValid, 1);
        chk("t4_pc40",     instructionPc, 16'h0040);
        chk("t4_instr40",  instruction, 32'h0800_0040);

        // ---- Halt opcode, then redirect out of halt ----
        mem_delay = 0;
        halt_en   = 1'b1;
        halt_addr = 16'd3;
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) cyc();
        chk("t5_addr3",  imemAddr, 3);
        cyc();
        chk("t5_halted", halted, 1);
        chk("t5_noreq",  imemReq, 0);
        chk("t5_valid",  instructionValid, 1);
        chk("t5_pc3",    instructionPc, 3);
        chk("t5_instr",  instruction, 32'hF800_0000);
        cyc();
        cyc();
        chk("t5_stay",   halted, 1);
        chk("t5_noreq2", imemReq, 0);
        chk("t5_empty",  instructionValid, 0);
        branchTaken  = 1'b1;
        branchTarget = 16'h0010;
        cyc();
        branchTaken = 1'b0;
        chk("t5_unhalt", halted, 0);
        cyc();
        chk("t5_req10",  imemReq, 1);
        chk("t5_addr10", imemAddr, 16'h0010);
        halt_en = 1'b0;

        // ---- PC wrap, then reset during an outstanding request ----
        mem_delay = 0;
        do_reset(1'b0);
        branchTaken  = 1'b1;
        branchTarget = 16'hFFFF;
        cyc();
        branchTaken = 1'b0;
        chk("t6_issue",   imemReq, 0);
        cyc();
        chk("t6_addrff",  imemAddr, 16'hFFFF);
        mem_delay = 5;
        cyc();
        chk("t6_wrap",    imemAddr, 16'h0000);
        chk("t6_pcff",    instructionPc, 16'hFFFF);
        chk("t6_req",     imemReq, 1);
        reset = 1'b1;
        tick();
        chk("t6_rst_req", imemReq, 0);
        chk("t6_rst_vld", instructionValid, 0);
        reset    = 1'b0;
        imemAck  = 1'b1;
        imemData = 32'h0800_0000;
        tick();
        imemAck  = 1'b0;
        chk("t6_late1",   instructionValid, 0);
        tick();
        chk("t6_late2",   instructionValid, 0);

        // ---- Randomized run against the transaction-level model ----
        do_reset(1'b0);
        q.delete();
        m_pc     = 16'h0;
        m_halted = 1'b0;
        doomed   = 1'b0;
        p_flush  = 1'b0;
        p_pop    = 1'b0;
        p_push   = 1'b0;
        n_push   = 0;
        for (int c = 0; c < 3000; c++) begin
            br   = ($urandom_range(0, 99) < 4);
            st   = ($urandom_range(0, 99) < 30);
            tgt  = 16'($urandom());
            ak   = imemReq && ($urandom_range(0, 99) < 60);
            opc  = ($urandom_range(0, 99) < 3) ? 5'h1F : 5'($urandom_range(0, 30));
            rdat = {opc, 27'($urandom())};
            stall        = st;
            branchTaken  = br;
            branchTarget = tgt;
            imemAck      = ak;
            imemData     = rdat;

            p_flush = br;
            p_pop   = !br && (q.size() != 0) && !st;
            p_push  = 1'b0;
            if (ak) begin
                if (!br && !doomed) begin
                    p_push     = 1'b1;
                    p_entry.dat = rdat;
                    p_entry.pc  = m_pc;
                    m_pc       = m_pc + 16'd1;
                    n_push     = n_push + 1;
                    if (opc == 5'h1F) m_halted = 1'b1;
                end
                doomed = 1'b0;
            end else if (br && imemReq && !doomed) begin
                doomed      = 1'b1;
                doomed_addr = m_pc;
            end
            if (br) begin
                m_pc     = tgt;
                m_halted = 1'b0;
            end

            tick();

            if (p_flush) begin
                q.delete();
            end else begin
                if (p_pop) void'(q.pop_front());
                if (p_push) q.push_back(p_entry);
            end

            chk("r_valid", instructionValid, (q.size() != 0));
            if (q.size() != 0) begin
                chk("r_pc",    instructionPc, q[0].pc);
                chk("r_instr", instruction, q[0].dat);
            end
            chk("r_halted", halted, m_halted);
            if (m_halted || q.size() == 2) chk("r_noreq", imemReq, 0);
            if (imemReq) chk("r_addr", imemAddr, doomed ? doomed_addr : m_pc);
        end
        chk("r_progress", (n_push > 100), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
